miniled_serial_rx: RTL and testbench

Synthesizable sink for the MiniLED panel serial bus (LE/DCLK/SDI/scan1-4): the receiving end of the interface our LED driver emits. It oversamples the bus on the 50 MHz system clock, deserializes MSB-first words, and classifies each LE pulse by its width in DCLK edges. It outputs one tagged word per latch, with channel index and scan row. It is used for on-board loopback checking of the driver output and as the capture front end of a panel-emulator build.

---
 rtl/miniled_serial_rx_pkg.sv | 13 +
 rtl/miniled_serial_rx_if.sv | 22 ++
 rtl/miniled_serial_rx_sync_edge.sv | 22 ++
 rtl/miniled_serial_rx.sv | 90 +++++++++
 tb/tb_miniled_serial_rx.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/miniled_serial_rx_pkg.sv
// miniled_pkg: shared constants, command encoding, FSM state type and scan helper for the MiniLED serial sink.
package miniled_pkg;
   localparam int DATA_W   = 16;
   localparam int CHANNELS = 48;
   localparam int CH_W     = 6;
   localparam int BC_W     = $clog2(DATA_W + 2);
   typedef enum logic [1:0] {CMD_NONE, CMD_DATA, CMD_GLATCH, CMD_CFG} cmd_e;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LE_HI, S_EMIT} state_e;
   // one-hot {scan4..scan1} -> row 0..3
   function automatic logic [1:0] scan_row(input logic [3:0] s);
      return {s[3] | s[2], s[3] | s[1]};
   endfunction
endpackage

// File: rtl/miniled_serial_rx_if.sv
// miniled_serial_rx_if: panel bus inputs plus tagged-word outputs.
//   slave  : the receiver (reads I_*, drives O_*)
//   master : the bus driver / checker (drives I_*, reads O_*)
interface miniled_serial_rx_if;
   import miniled_pkg::*;
   logic              I_dclk;
   logic              I_sdi;
   logic              I_le;
   logic [3:0]        I_scan;
   logic [DATA_W-1:0] O_word;
   logic              O_word_vld;
   logic [1:0]        O_cmd;
   logic [CH_W-1:0]   O_ch_idx;
   logic [1:0]        O_row;
   logic              O_frame;
   logic              O_err_len;
   logic              O_err_scan;
   modport slave (input I_dclk, I_sdi, I_le, I_scan,
                  output O_word, O_word_vld, O_cmd, O_ch_idx, O_row, O_frame, O_err_len, O_err_scan);
   modport master (output I_dclk, I_sdi, I_le, I_scan,
                   input O_word, O_word_vld, O_cmd, O_ch_idx, O_row, O_frame, O_err_len, O_err_scan);
endinterface

// File: rtl/miniled_serial_rx_sync_edge.sv
// sync_edge: 2-FF synchronizer with a third stage for rise/fall strobes.
//   I_clk, I_rst_n : clock, async active-low reset
//   d    : asynchronous inputs      q    : synchronized level
//   rise : one-cycle rise strobe    fall : one-cycle fall strobe
module sync_edge #(
   parameter int         W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         I_clk,
   input  logic         I_rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);
   logic [W-1:0] s1, s3;
   always_ff @(posedge I_clk or negedge I_rst_n)
      if (!I_rst_n) {s1, q, s3} <= {3{RST_VAL}};
      else          {s1, q, s3} <= {d, s1, q};
   assign rise = q & ~s3;
   assign fall = ~q & s3;
endmodule

// File: rtl/miniled_serial_rx.sv
// miniled_serial_rx: oversampling sink for the MiniLED LE/DCLK/SDI/scan bus; emits one tagged word per LE pulse.
//   I_clk, I_rst_n : 50 MHz system clock, async active-low reset
//   bus (slave)    : I_dclk/I_sdi/I_le/I_scan in; O_word, O_word_vld, O_cmd, O_ch_idx,
//                    O_row, O_frame, O_err_len, O_err_scan out
module miniled_serial_rx
   import miniled_pkg::*;
(
   input logic               I_clk,
   input logic               I_rst_n,
   miniled_serial_rx_if.slave bus
);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);
   localparam logic [BC_W-1:0] BC_MAX  = BC_W'(DATA_W + 1);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
   logic [6:0]        sq, rise, fall;
   logic              dclk_r, le_r, le_f, sdi;
   logic [3:0]        scan;
   state_e            state;
   logic [DATA_W-1:0] shreg;
   logic [BC_W-1:0]   bit_cnt;
   logic [1:0]        le_cnt;
   logic [CH_W-1:0]   ch_cnt;
   logic              unused_sync;
   // bit map {scan[3:0], sdi, le, dclk}; scan resets to scan1 so reset itself is not a scan error
   sync_edge #(.W(7), .RST_VAL(7'b0001_000)) u_sync (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .d       ({bus.I_scan, bus.I_sdi, bus.I_le, bus.I_dclk}),
      .q       (sq),
      .rise    (rise),
      .fall    (fall)
   );
   assign dclk_r      = rise[0];
   assign le_r        = rise[1];
   assign le_f        = fall[1];
   assign sdi         = sq[2];
   assign scan        = sq[6:3];
   assign unused_sync = ^{sq[1:0], rise[6:2], fall[6:2], fall[0]};
   always_ff @(posedge I_clk or negedge I_rst_n)
      if (!I_rst_n) begin
         state          <= S_IDLE;
         shreg          <= '0;
         bit_cnt        <= '0;
         le_cnt         <= '0;
         ch_cnt         <= '0;
         bus.O_word     <= '0;
         bus.O_word_vld <= 1'b0;
         bus.O_cmd      <= CMD_NONE;
         bus.O_ch_idx   <= '0;
         bus.O_row      <= '0;
         bus.O_frame    <= 1'b0;
         bus.O_err_len  <= 1'b0;
         bus.O_err_scan <= 1'b0;
      end else begin
         bus.O_word_vld <= 1'b0;
         bus.O_frame    <= 1'b0;
         bus.O_err_len  <= 1'b0;
         if ($onehot(scan)) bus.O_row <= scan_row(scan);
         else bus.O_err_scan <= 1'b1;
         case (state)
            // a DCLK rise coinciding with LE rise is shifted before entering LE_HI
            S_IDLE, S_SHIFT: begin
               if (dclk_r) begin
                  shreg   <= {shreg[DATA_W-2:0], sdi};
                  bit_cnt <= (bit_cnt == BC_MAX) ? bit_cnt : bit_cnt + 1'b1;
               end
               state <= le_r ? S_LE_HI : dclk_r ? S_SHIFT : state;
            end
            // DCLK edges under LE only measure the pulse width; bit_cnt stays frozen
            S_LE_HI: begin
               if (dclk_r && le_cnt != 2'd3) le_cnt <= le_cnt + 1'b1;
               if (le_f) state <= S_EMIT;
            end
            S_EMIT: begin
               bus.O_word     <= shreg;
               bus.O_word_vld <= 1'b1;
               bus.O_cmd      <= le_cnt;  // pulse width in DCLK edges is the command code
               bus.O_ch_idx   <= ch_cnt;
               bus.O_frame    <= le_cnt == CMD_GLATCH;
               bus.O_err_len  <= le_cnt != CMD_NONE && bit_cnt != BC_FULL;
               ch_cnt         <= le_cnt == CMD_GLATCH ? '0 :
                                 le_cnt != CMD_DATA ? ch_cnt :
                                 ch_cnt == CH_LAST ? '0 : ch_cnt + 1'b1;
               bit_cnt        <= '0;
               le_cnt         <= '0;
               state          <= S_IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_miniled_serial_rx.sv
// tb_miniled_serial_rx: directed self-checking bench for miniled_serial_rx.
module tb_miniled_serial_rx;
   import miniled_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat;
   logic        got;
   logic [15:0] c_word;
   logic [1:0]  c_cmd, c_row;
   logic [5:0]  c_ch;
   logic        c_frame, c_err;
   logic [15:0] w;
   miniled_serial_rx_if bus ();
   miniled_serial_rx dut (.I_clk(clk), .I_rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bit_out(input logic b, input logic with_le);
      bus.I_sdi = b;
      cyc(2);
      bus.I_dclk = 1'b1;
      if (with_le) bus.I_le = 1'b1;
      cyc(2);
      bus.I_dclk = 1'b0;
   endtask
   // shift nbits of v MSB-first, LE for le_edges DCLK edges, then capture the strobe
   task automatic send(input logic [15:0] v, input int nbits, input int le_edges, input logic coinc = 1'b0);
      for (int i = nbits - 1; i >= 0; i--) bit_out(v[i], coinc && i == 0);
      if (!coinc) begin
         cyc(2);
         bus.I_le = 1'b1;
      end
      cyc(2);
      for (int i = 0; i < le_edges; i++) begin
         bus.I_dclk = 1'b1;
         cyc(2);
         bus.I_dclk = 1'b0;
         cyc(2);
      end
      bus.I_le = 1'b0;
      lat = 0;
      got = 1'b0;
      while (lat < 10 && !got) begin
         cyc(1);
         lat++;
         got = bus.O_word_vld;
      end
      c_word  = bus.O_word;
      c_cmd   = bus.O_cmd;
      c_ch    = bus.O_ch_idx;
      c_row   = bus.O_row;
      c_frame = bus.O_frame;
      c_err   = bus.O_err_len;
      check("strobe_seen", 32'(got), 1);
      cyc(1);
      check("strobe_one_cycle", 32'(bus.O_word_vld), 0);
   endtask
   initial begin
      bus.I_dclk = 1'b0;
      bus.I_sdi  = 1'b0;
      bus.I_le   = 1'b0;
      bus.I_scan = 4'b0001;
      cyc(3);
      check("rst_word", 32'(bus.O_word), 0);
      check("rst_vld", 32'(bus.O_word_vld), 0);
      check("rst_cmd", 32'(bus.O_cmd), 0);
      check("rst_ch", 32'(bus.O_ch_idx), 0);
      check("rst_row", 32'(bus.O_row), 0);
      check("rst_frame", 32'(bus.O_frame), 0);
      check("rst_err_len", 32'(bus.O_err_len), 0);
      check("rst_err_scan", 32'(bus.O_err_scan), 0);
      rst_n = 1'b1;
      cyc(3);
      send(16'hA5C3, 16, 1);
      check("t1_latency", lat, 4);
      check("t1_word", 32'(c_word), 32'hA5C3);
      check("t1_cmd", 32'(c_cmd), 1);
      check("t1_ch", 32'(c_ch), 0);
      check("t1_row", 32'(c_row), 0);
      check("t1_err", 32'(c_err), 0);
      send(16'h0F0F, 16, 0);
      check("none_word", 32'(c_word), 32'h0F0F);
      check("none_cmd", 32'(c_cmd), 0);
      check("none_err", 32'(c_err), 0);
      send(16'hFFFF, 16, 2);
      check("gl0_cmd", 32'(c_cmd), 2);
      check("gl0_frame", 32'(c_frame), 1);
      bus.I_scan = 4'b0100;
      for (int i = 0; i < 48; i++) begin
         w = 16'h2A5C + 16'(i * 309);
         send(w, 16, 1);
         check("run48_word", 32'(c_word), 32'(w));
         check("run48_ch", 32'(c_ch), 32'(i));
         check("run48_row", 32'(c_row), 2);
         check("run48_frame", 32'(c_frame), 0);
      end
      send(16'h8001, 16, 2);
      check("gl1_cmd", 32'(c_cmd), 2);
      check("gl1_frame", 32'(c_frame), 1);
      check("gl1_err", 32'(c_err), 0);
      for (int i = 0; i < 49; i++) begin
         w = 16'h71E3 ^ 16'(i * 4099);
         send(w, 16, 1);
         check("run49_word", 32'(c_word), 32'(w));
         check("run49_ch", 32'(c_ch), 32'(i % 48));
      end
      send(16'hC0DE, 16, 1, 1'b1);
      check("coinc_word", 32'(c_word), 32'hC0DE);
      check("coinc_cmd", 32'(c_cmd), 1);
      check("coinc_ch", 32'(c_ch), 1);
      check("coinc_err", 32'(c_err), 0);
      send(16'h1234, 15, 1);
      check("short_cmd", 32'(c_cmd), 1);
      check("short_err", 32'(c_err), 1);
      check("short_ch", 32'(c_ch), 2);
      send(16'hBEEF, 16, 4);
      check("cfg_word", 32'(c_word), 32'hBEEF);
      check("cfg_cmd", 32'(c_cmd), 3);
      check("cfg_err", 32'(c_err), 0);
      check("cfg_frame", 32'(c_frame), 0);
      check("scan_ok_before", 32'(bus.O_err_scan), 0);
      bus.I_scan = 4'b0110;
      cyc(5);
      check("scan_bad_err", 32'(bus.O_err_scan), 1);
      check("scan_bad_row_hold", 32'(bus.O_row), 2);
      bus.I_scan = 4'b0001;
      cyc(5);
      check("scan_sticky", 32'(bus.O_err_scan), 1);
      check("scan_row_back", 32'(bus.O_row), 0);
      for (int i = 7; i >= 0; i--) bit_out(1'(8'hD7 >> i), 1'b0);
      rst_n = 1'b0;
      cyc(2);
      check("mid_rst_vld", 32'(bus.O_word_vld), 0);
      check("mid_rst_word", 32'(bus.O_word), 0);
      check("mid_rst_err_scan", 32'(bus.O_err_scan), 0);
      rst_n = 1'b1;
      cyc(3);
      send(16'h3C96, 16, 1);
      check("post_rst_word", 32'(c_word), 32'h3C96);
      check("post_rst_cmd", 32'(c_cmd), 1);
      check("post_rst_ch", 32'(c_ch), 0);
      check("post_rst_err_len", 32'(c_err), 0);
      check("post_rst_err_scan", 32'(bus.O_err_scan), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
